mem_arbiter: RTL and testbench

Sequences a single shared, single-port backing memory between the pipeline's instruction-fetch port and its MEM-stage data port. Accepts at most one transaction at a time and holds the losing or waiting requester with a stall. Drives a req/ack handshake to the memory and aborts hung transactions with a watchdog. Sits between the IF and MEM stages and the unified memory; its stall outputs are ORed into the existing PC/IF_ID hold and pipeline-freeze logic.

---
 rtl/cpu_mem_pkg.sv | 23 ++
 rtl/mem_timeout_ctr.sv | 29 ++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the IF/MEM memory arbiter and the pipeline stall logic.
package cpu_mem_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_BUSY_I = 3'd1,
    ARB_BUSY_D = 3'd2,
    ARB_DONE_I = 3'd3,
    ARB_DONE_D = 3'd4
  } arb_state_t;

  // Which requester owns the memory; also consumed by the pipeline stall logic.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } arb_grant_t;

  localparam int unsigned ARB_ERR_W = 64;
  // Read data returned on a timed-out access; truncated to the port width, so ports up to 64 bits.
  localparam logic [ARB_ERR_W-1:0] ARB_ERR_DATA = '1;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog for one memory transaction: pulses expired in the TIMEOUT-th enabled cycle.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Count holds the number of prior waiting cycles, so this cycle is the TIMEOUT-th one.
  assign expired = enable & (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF fetches and MEM-stage loads/stores onto one single-port memory with a req/ack watchdog.
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_stall_o,
  input  logic              d_re_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(ARB_ERR_DATA);

  arb_state_t        state_q, state_d;
  arb_grant_t        grant_c;
  logic              d_any_c, busy_c, expired_c;
  logic              mem_req_d, mem_we_d, err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;

  assign d_any_c = d_re_i | d_we_i;
  assign busy_c  = (state_q == ARB_BUSY_I) | (state_q == ARB_BUSY_D);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clear   (~busy_c),
    .enable  (busy_c & ~mem_ack_i),
    .expired (expired_c)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Next state; data port wins because a MEM stall already freezes IF.
  always_comb begin
    state_d = state_q;
    grant_c = GNT_NONE;
    if (d_any_c)       grant_c = GNT_D;
    else if (if_req_i) grant_c = GNT_IF;
    case (state_q)
      ARB_IDLE: begin
        case (grant_c)
          GNT_D:   state_d = ARB_BUSY_D;
          GNT_IF:  state_d = ARB_BUSY_I;
          default: state_d = ARB_IDLE;
        endcase
      end
      ARB_BUSY_I: if (mem_ack_i | expired_c) state_d = ARB_DONE_I;
      ARB_BUSY_D: if (mem_ack_i | expired_c) state_d = ARB_DONE_D;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Next values of the registered outputs; an ack beats a same-cycle expiry.
  always_comb begin
    mem_req_d   = (state_d == ARB_BUSY_I) | (state_d == ARB_BUSY_D);
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    if_rdata_d  = if_rdata_o;
    d_rdata_d   = d_rdata_o;
    err_d       = err_o | expired_c;
    if (state_q == ARB_IDLE) begin
      if (grant_c == GNT_D) begin
        mem_we_d    = d_we_i;
        mem_addr_d  = d_addr_i;
        mem_wdata_d = d_wdata_i;
      end else if (grant_c == GNT_IF) begin
        mem_we_d   = 1'b0;
        mem_addr_d = if_addr_i;
      end
    end
    if (state_q == ARB_BUSY_I) begin
      if (mem_ack_i)      if_rdata_d = mem_rdata_i;
      else if (expired_c) if_rdata_d = ERR_DATA;
    end
    if (state_q == ARB_BUSY_D) begin
      if (mem_ack_i)      d_rdata_d = mem_we_o ? d_rdata_o : mem_rdata_i;
      else if (expired_c) d_rdata_d = ERR_DATA;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      if_rdata_o  <= if_rdata_d;
      d_rdata_o   <= d_rdata_d;
      err_o       <= err_d;
    end
  end

  // Stalls must drop combinationally in the DONE cycle so the pipeline advances there.
  assign if_stall_o = if_req_i & (state_q != ARB_DONE_I);
  assign d_stall_o  = d_any_c  & (state_q != ARB_DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table of single transactions against a latency-programmable memory, plus corner sequences.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_stall_o;
  logic          d_re_i = 1'b0;
  logic          d_we_i = 1'b0;
  logic [AW-1:0] d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0;
  logic [DW-1:0] d_rdata_o;
  logic          d_stall_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_ack_i = 1'b0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          err_o;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
    .d_re_i(d_re_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  // Memory model: acks in the ack_lat-th cycle of a request (0 = never); force_ack acks unconditionally.
  int   ack_lat = 0;
  logic force_ack = 1'b0;
  int   busy_n = 0;
  always @(negedge clk) begin
    if (mem_req_o) begin
      busy_n    = busy_n + 1;
      mem_ack_i = force_ack | ((ack_lat != 0) && (busy_n == ack_lat));
    end else begin
      busy_n    = 0;
      mem_ack_i = force_ack;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stall;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   stalls;
    bit   done;
    logic st;
    @(negedge clk);
    ack_lat     = v.lat;
    mem_rdata_i = v.mrdata;
    if (v.is_d) begin
      d_re_i = v.re; d_we_i = v.we; d_addr_i = v.addr; d_wdata_i = v.wdata;
    end else begin
      if_req_i = 1'b1; if_addr_i = v.addr;
    end
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.stall = v.exp_stall;
    sb.push_back(e);
    #1;
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      st = v.is_d ? d_stall_o : if_stall_o;
      if (mem_req_o) begin
        check("mem_addr", mem_addr_o, v.addr);
        check("mem_we", 32'(mem_we_o), 32'(v.is_d & v.we));
        if (v.is_d && v.we) check("mem_wdata", mem_wdata_o, v.wdata);
      end
      if (st) begin
        stalls++;
      end else begin
        done = 1'b1;
        e = sb.pop_front();
        check("stall_cycles", 32'(stalls), 32'(e.stall));
        check(v.is_d ? "d_rdata" : "if_rdata", v.is_d ? d_rdata_o : if_rdata_o, e.rdata);
        check("err", 32'(err_o), 32'(e.err));
        check("req_low_in_done", 32'(mem_req_o), 32'd0);
      end
    end
    if (!done) begin
      check("complete", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    if_req_i = 1'b0; d_re_i = 1'b0; d_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] ds_exp, is_exp, rq_exp;
    int         stalls;
    bit         done;

    //          is_d re  we   addr          wdata         mrdata        lat exp_rdata     err  stall
    vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0,         32'h00500093, 1, 32'h00500093, 1'b0, 2};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h80, 32'h0,         32'h12345678, 3, 32'h12345678, 1'b0, 4};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D,  32'hDEADBEEF, 2, 32'h12345678, 1'b0, 3};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h44, 32'h0BADF00D,  32'hDEADBEEF, 1, 32'h12345678, 1'b0, 2};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h84, 32'h0,         32'hA5A5A5A5, 4, 32'hA5A5A5A5, 1'b0, 5};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h14, 32'h0,         32'h00A00113, 2, 32'h00A00113, 1'b0, 3};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h88, 32'h0,         32'h0,        0, 32'hFFFFFFFF, 1'b1, 5};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h18, 32'h0,         32'h11111111, 1, 32'h11111111, 1'b1, 2};

    // Reset values
    @(negedge clk); @(negedge clk);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);
    check("rst_if_rdata", if_rdata_o, 32'd0);
    check("rst_d_rdata", d_rdata_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_stalls", 32'({if_stall_o, d_stall_o}), 32'd0);
    rst_n = 1'b1;

    // Ack while idle must be ignored
    @(negedge clk);
    force_ack = 1'b1; mem_rdata_i = 32'h55555555;
    repeat (3) @(negedge clk);
    check("idle_ack_req", 32'(mem_req_o), 32'd0);
    check("idle_ack_if_rdata", if_rdata_o, 32'd0);
    check("idle_ack_d_rdata", d_rdata_o, 32'd0);
    check("idle_ack_err", 32'(err_o), 32'd0);
    force_ack = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Simultaneous fetch and load: data first, one idle cycle, then fetch
    ds_exp = 10'b0000001111;
    is_exp = 10'b0111111111;
    rq_exp = 10'b0111001110;
    @(negedge clk);
    ack_lat = 3; mem_rdata_i = 32'h0BEEF000;
    if_req_i = 1'b1; if_addr_i = 32'h20;
    d_re_i = 1'b1; d_addr_i = 32'h80;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("both_d_stall_c%0d", c), 32'(d_stall_o), 32'(ds_exp[c]));
      check($sformatf("both_if_stall_c%0d", c), 32'(if_stall_o), 32'(is_exp[c]));
      check($sformatf("both_req_c%0d", c), 32'(mem_req_o), 32'(rq_exp[c]));
      if (c == 1) check("both_first_addr", mem_addr_o, 32'h80);
      if (c == 6) begin
        check("both_second_addr", mem_addr_o, 32'h20);
        check("both_second_we", 32'(mem_we_o), 32'd0);
      end
      if (c == 4) begin
        check("both_d_rdata", d_rdata_o, 32'h0BEEF000);
        d_re_i = 1'b0;
        mem_rdata_i = 32'h00C00193;
      end
      if (c == 9) begin
        check("both_if_rdata", if_rdata_o, 32'h00C00193);
        if_req_i = 1'b0;
      end
    end

    run_vec(vecs[6]);
    run_vec(vecs[7]);
    check("err_sticky", 32'(err_o), 32'd1);

    // Reset in the middle of a data read, then re-issue
    @(negedge clk);
    ack_lat = 0; mem_rdata_i = 32'h00000077;
    d_re_i = 1'b1; d_addr_i = 32'h90;
    @(negedge clk); @(negedge clk);
    check("mid_busy_req", 32'(mem_req_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_req_o), 32'd0);
    check("async_err_clear", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ack_lat = 1;
    #1;
    check("post_rst_idle_req", 32'(mem_req_o), 32'd0);
    stalls = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      if (d_stall_o) stalls++;
      else done = 1'b1;
    end
    check("reissue_done", 32'(done), 32'd1);
    check("reissue_stalls", 32'(stalls), 32'd2);
    check("reissue_rdata", d_rdata_o, 32'h00000077);
    check("reissue_err", 32'(err_o), 32'd0);
    d_re_i = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
